// File: rtl/gym_pkg.sv
// Shared gym definitions: facing directions, keycodes, tile geometry and
// the position payload exchanged with the spin-tile stage.
package gym_pkg;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_UP    = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;

    localparam int unsigned POS_W       = 10;
    localparam int unsigned GYM_TILE_PX = 16;
    localparam int unsigned XRIGHT_OFS  = 15;
    localparam int unsigned YBOTTOM_OFS = 20;

    typedef struct packed {
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
    } pos_t;

    function automatic logic key_is_move(input logic [7:0] k);
        return (k == KEY_W) || (k == KEY_S) || (k == KEY_A) || (k == KEY_D);
    endfunction

    // Non-movement keys fall back to DOWN; callers gate on key_is_move.
    function automatic dir_t key_to_dir(input logic [7:0] k);
        case (k)
            KEY_W:   return DIR_UP;
            KEY_A:   return DIR_LEFT;
            KEY_D:   return DIR_RIGHT;
            default: return DIR_DOWN;
        endcase
    endfunction

endpackage

// File: rtl/gym_player_motion_if.sv
// Player-motion bus: frame sync, keyboard, map lookup and tile-stage
// handshake in; position, facing and animation out.
interface gym_player_motion_if;
    logic       VGA_VS;
    logic [7:0] keycode;
    logic       blocked;
    logic       atTile;
    logic [1:0] spin_direction;
    logic [9:0] tele_x;
    logic [9:0] tele_y;
    logic [9:0] target_x;
    logic [9:0] target_y;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic [9:0] xright;
    logic [9:0] ybottom;
    logic [1:0] facing;
    logic       moving;
    logic       walk_frame;

    modport master (
        output VGA_VS, keycode, blocked, atTile, spin_direction, tele_x, tele_y,
        input  target_x, target_y, player_x, player_y, xright, ybottom,
               facing, moving, walk_frame
    );

    modport slave (
        input  VGA_VS, keycode, blocked, atTile, spin_direction, tele_x, tele_y,
        output target_x, target_y, player_x, player_y, xright, ybottom,
               facing, moving, walk_frame
    );
endinterface

// File: rtl/gym_player_motion_vs_tick_sync.sv
// Brings VGA_VS into the clk domain and emits a registered one-cycle pulse
// per rising edge (three clocks after the edge).
module vs_tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic vs_async,
    output logic frame_tick
);
    logic [2:0] sync_q, sync_d;
    logic       tick_q, tick_d;

    always_comb begin
        sync_d = {sync_q[1:0], vs_async};
        tick_d = sync_q[1] & ~sync_q[2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            tick_q <= tick_d;
        end
    end

    assign frame_tick = tick_q;
endmodule

// File: rtl/gym_player_motion.sv
// Frame-paced tile-by-tile player movement; yields to the tile stage while
// it reports atTile.
module gym_player_motion
    import gym_pkg::*;
#(
    parameter int TILE_PX = int'(GYM_TILE_PX),
    parameter int STEP_PX = 2,
    parameter int START_X = 288,
    parameter int START_Y = 347,
    parameter int X_MIN   = 0,
    parameter int X_MAX   = 448,
    parameter int Y_MIN   = 59,
    parameter int Y_MAX   = 363
) (
    input logic              Clk,
    input logic              Reset,
    gym_player_motion_if.slave bus
);
    localparam int unsigned CNT_W = 8;
    localparam int          STEPS = TILE_PX / STEP_PX;

    typedef enum logic [1:0] {ST_IDLE, ST_WALK, ST_LOCKED} state_t;

    state_t           state_q, state_d;
    pos_t             pos_q, pos_d;
    dir_t             facing_q, facing_d;
    logic             walk_frame_q, walk_frame_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;

    logic frame_tick;
    logic key_valid;
    dir_t key_dir;
    int   tx_i, ty_i;
    logic in_bounds;

    vs_tick_sync u_vs_tick_sync (
        .clk       (Clk),
        .rst       (Reset),
        .vs_async  (bus.VGA_VS),
        .frame_tick(frame_tick)
    );

    // Candidate tile one pitch away; bounds checked in int so underflow is caught.
    always_comb begin
        key_valid = key_is_move(bus.keycode);
        key_dir   = key_to_dir(bus.keycode);
        tx_i      = int'(pos_q.x);
        ty_i      = int'(pos_q.y);
        case (key_dir)
            DIR_DOWN:  ty_i = ty_i + TILE_PX;
            DIR_UP:    ty_i = ty_i - TILE_PX;
            DIR_LEFT:  tx_i = tx_i - TILE_PX;
            DIR_RIGHT: tx_i = tx_i + TILE_PX;
        endcase
        in_bounds = (tx_i >= X_MIN) && (tx_i <= X_MAX) &&
                    (ty_i >= Y_MIN) && (ty_i <= Y_MAX);
    end

    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        facing_d     = facing_q;
        walk_frame_d = walk_frame_q;
        step_cnt_d   = step_cnt_q;
        if (frame_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.atTile) begin
                        state_d = ST_LOCKED;
                    end else if (key_valid) begin
                        facing_d = key_dir;
                        if (!bus.blocked && in_bounds) begin
                            state_d    = ST_WALK;
                            step_cnt_d = '0;
                        end
                    end
                end
                ST_WALK: begin
                    case (facing_q)
                        DIR_DOWN:  pos_d.y = pos_q.y + POS_W'(STEP_PX);
                        DIR_UP:    pos_d.y = pos_q.y - POS_W'(STEP_PX);
                        DIR_LEFT:  pos_d.x = pos_q.x - POS_W'(STEP_PX);
                        DIR_RIGHT: pos_d.x = pos_q.x + POS_W'(STEP_PX);
                    endcase
                    step_cnt_d = step_cnt_q + CNT_W'(1);
                    if (step_cnt_q[1:0] == 2'd3) walk_frame_d = ~walk_frame_q;
                    if (step_cnt_q == CNT_W'(STEPS - 1)) begin
                        state_d    = ST_IDLE;
                        step_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    pos_d.x      = bus.tele_x;
                    pos_d.y      = bus.tele_y;
                    facing_d     = dir_t'(bus.spin_direction);
                    walk_frame_d = 1'b0;
                    if (!bus.atTile) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            pos_q.x      <= POS_W'(START_X);
            pos_q.y      <= POS_W'(START_Y);
            facing_q     <= DIR_DOWN;
            walk_frame_q <= 1'b0;
            step_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            facing_q     <= facing_d;
            walk_frame_q <= walk_frame_d;
            step_cnt_q   <= step_cnt_d;
        end
    end

    assign bus.target_x   = POS_W'(tx_i);
    assign bus.target_y   = POS_W'(ty_i);
    assign bus.player_x   = pos_q.x;
    assign bus.player_y   = pos_q.y;
    assign bus.xright     = pos_q.x + POS_W'(XRIGHT_OFS);
    assign bus.ybottom    = pos_q.y + POS_W'(YBOTTOM_OFS);
    assign bus.facing     = facing_q;
    assign bus.moving     = (state_q == ST_WALK);
    assign bus.walk_frame = walk_frame_q;
endmodule

// File: tb/tb_gym_player_motion.sv
// Randomised and directed frames against a tile-walk reference model; a
// monitor pops expected snapshots and compares them to the DUT outputs.
module tb_gym_player_motion;

    logic Clk;
    logic Reset;

    gym_player_motion_if bus_if ();

    gym_player_motion dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus_if)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string name;
        int    px, py, xr, yb, face, mov, wf;
        int    tv, tx, ty;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: position, facing, animation phase, walk progress, lock.
    int mx, my, mface, mframe, mleft, mdone, mlocked;

    function automatic int kdir(input int k);
        case (k)
            'h1A:    return 1;
            'h16:    return 0;
            'h04:    return 2;
            'h07:    return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int tgt_x(input int x, input int d);
        return (d == 2) ? x - 16 : (d == 3) ? x + 16 : x;
    endfunction

    function automatic int tgt_y(input int y, input int d);
        return (d == 1) ? y - 16 : (d == 0) ? y + 16 : y;
    endfunction

    task automatic model_reset();
        mx = 288; my = 347; mface = 0; mframe = 0;
        mleft = 0; mdone = 0; mlocked = 0;
    endtask

    task automatic model_tick();
        int d, nx, ny;
        if (mlocked != 0) begin
            mx = int'(bus_if.tele_x);
            my = int'(bus_if.tele_y);
            mface = int'(bus_if.spin_direction);
            mframe = 0;
            if (!bus_if.atTile) mlocked = 0;
        end else if (mleft > 0) begin
            case (mface)
                0: my += 2;
                1: my -= 2;
                2: mx -= 2;
                default: mx += 2;
            endcase
            mdone++;
            if (mdone % 4 == 0) mframe ^= 1;
            mleft--;
        end else if (bus_if.atTile) begin
            mlocked = 1;
        end else begin
            d = kdir(int'(bus_if.keycode));
            if (d >= 0) begin
                mface = d;
                nx = tgt_x(mx, d);
                ny = tgt_y(my, d);
                if (!bus_if.blocked && nx >= 0 && nx <= 448 && ny >= 59 && ny <= 363) begin
                    mleft = 8;
                    mdone = 0;
                end
            end
        end
    endtask

    task automatic push_exp(input string nm);
        exp_t e;
        int d;
        d = kdir(int'(bus_if.keycode));
        e.name = nm;
        e.px = mx; e.py = my;
        e.xr = (mx + 15) % 1024; e.yb = (my + 20) % 1024;
        e.face = mface; e.mov = (mleft > 0) ? 1 : 0; e.wf = mframe;
        e.tv = (d >= 0) ? 1 : 0;
        e.tx = tgt_x(mx, d) & 1023;
        e.ty = tgt_y(my, d) & 1023;
        exp_q.push_back(e);
    endtask

    // One VS pulse; inputs must already be set by the caller and stay put.
    task automatic do_frame(input string nm);
        logic [7:0] k_save;
        logic       a_save;
        @(negedge Clk) bus_if.VGA_VS = 1'b1;
        repeat (6) @(negedge Clk);
        model_tick();
        push_exp(nm);
        repeat (3) @(negedge Clk);
        bus_if.VGA_VS = 1'b0;
        repeat (2) @(negedge Clk);
        k_save = bus_if.keycode;
        a_save = bus_if.atTile;
        bus_if.keycode = 8'($urandom_range(0, 255));
        bus_if.atTile  = 1'($urandom_range(0, 1));
        @(negedge Clk);
        bus_if.keycode = k_save;
        bus_if.atTile  = a_save;
        repeat (2) @(negedge Clk);
    endtask

    // Monitor: compares each queued snapshot at the next falling clock edge.
    initial begin
        exp_t e;
        int ax, ay, axr, ayb, af, am, aw, atx, aty;
        forever begin
            @(negedge Clk);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                ax  = int'(bus_if.player_x);  ay  = int'(bus_if.player_y);
                axr = int'(bus_if.xright);    ayb = int'(bus_if.ybottom);
                af  = int'(bus_if.facing);    am  = int'(bus_if.moving);
                aw  = int'(bus_if.walk_frame);
                atx = int'(bus_if.target_x);  aty = int'(bus_if.target_y);
                n_vec++;
                if (ax != e.px || ay != e.py || axr != e.xr || ayb != e.yb ||
                    af != e.face || am != e.mov || aw != e.wf ||
                    (e.tv != 0 && (atx != e.tx || aty != e.ty))) begin
                    n_err++;
                    $display("FAIL %s: got pos=(%0d,%0d) br=(%0d,%0d) face=%0d mov=%0d wf=%0d tgt=(%0d,%0d); want pos=(%0d,%0d) br=(%0d,%0d) face=%0d mov=%0d wf=%0d tgt=(%0d,%0d)",
                             e.name, ax, ay, axr, ayb, af, am, aw, atx, aty,
                             e.px, e.py, e.xr, e.yb, e.face, e.mov, e.wf, e.tx, e.ty);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

    task automatic set_in(input logic [7:0] k, input logic blk, input logic at);
        bus_if.keycode = k;
        bus_if.blocked = blk;
        bus_if.atTile  = at;
    endtask

    initial begin
        int lock_left;
        int r;
        int waited;
        Reset = 1'b1;
        bus_if.VGA_VS = 1'b0;
        bus_if.spin_direction = 2'd0;
        bus_if.tele_x = 10'd288;
        bus_if.tele_y = 10'd347;
        set_in(8'h00, 1'b0, 1'b0);
        model_reset();
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        push_exp("reset_state");
        repeat (2) @(negedge Clk);

        for (int i = 0; i < 5; i++) do_frame("idle_no_key");

        set_in(8'h07, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) do_frame("walk_right");
        set_in(8'h00, 1'b0, 1'b0);
        do_frame("walk_right_done");

        set_in(8'h1A, 1'b0, 1'b0);
        do_frame("walk_up_press");
        set_in(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) do_frame("walk_up_released");

        set_in(8'h04, 1'b1, 1'b0);
        do_frame("left_blocked");
        set_in(8'h00, 1'b0, 1'b0);
        do_frame("left_blocked_hold");

        set_in(8'h00, 1'b0, 1'b1);
        bus_if.tele_x = 10'd288;
        bus_if.tele_y = 10'd347;
        for (int i = 0; i < 40; i++) begin
            bus_if.spin_direction = 2'(i);
            do_frame("lock_spin");
        end
        bus_if.tele_x = 10'd448;
        bus_if.tele_y = 10'd363;
        do_frame("lock_tele_far");
        bus_if.atTile = 1'b0;
        do_frame("lock_release");
        set_in(8'h16, 1'b0, 1'b0);
        do_frame("down_oob_bottom");
        set_in(8'h07, 1'b0, 1'b0);
        do_frame("right_oob_edge");

        bus_if.tele_x = 10'd0;
        bus_if.tele_y = 10'd59;
        set_in(8'h00, 1'b0, 1'b1);
        do_frame("lock_to_origin");
        do_frame("lock_to_origin");
        bus_if.atTile = 1'b0;
        do_frame("lock_to_origin_rel");
        set_in(8'h04, 1'b0, 1'b0);
        do_frame("left_underflow");
        set_in(8'h1A, 1'b0, 1'b0);
        do_frame("up_oob_top");

        set_in(8'h07, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) do_frame("walk_before_reset");
        Reset = 1'b1;
        model_reset();
        @(negedge Clk);
        push_exp("async_reset_midwalk");
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        for (int i = 0; i < 8; i++) do_frame("walk_after_reset");
        set_in(8'h00, 1'b0, 1'b0);
        do_frame("walk_after_reset_done");

        lock_left = 0;
        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1:    bus_if.keycode = 8'h1A;
                2, 3:    bus_if.keycode = 8'h16;
                4, 5:    bus_if.keycode = 8'h04;
                6, 7:    bus_if.keycode = 8'h07;
                8:       bus_if.keycode = 8'h00;
                default: bus_if.keycode = 8'($urandom_range(0, 255));
            endcase
            bus_if.blocked = ($urandom_range(0, 3) == 0);
            if (lock_left == 0 && $urandom_range(0, 19) == 0) begin
                lock_left = int'($urandom_range(2, 5));
                bus_if.tele_x = 10'(16 * $urandom_range(0, 28));
                bus_if.tele_y = 10'(59 + 16 * $urandom_range(0, 19));
            end
            bus_if.atTile = (lock_left > 0);
            if (lock_left > 0) lock_left--;
            bus_if.spin_direction = 2'($urandom_range(0, 3));
            do_frame("random");
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(negedge Clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d snapshots left unchecked, want 0", exp_q.size());
        end
        repeat (2) @(negedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
